// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared constants and state encoding for the decode-stage hazard controller
package hazard_ctrl_pkg;

  localparam int HC_REG_W    = 3;
  localparam int HC_SB_DEPTH = 3;
  localparam int HC_CNT_W    = 16;

  // 2'b11 is unused; the FSM recovers from it by returning to ST_RUN.
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } hc_state_t;

endpackage

// File: rtl/hazard_ctrl_sb.sv
// rtl/hazard_ctrl_sb.sv - in-flight register-write scoreboard with RAW compare
//  clk, rst             clock, synchronous active-high reset
//  issue_v, issue_reg   write entering EX this cycle (v=0 for bubbles/flushes)
//  rs_sel/rs_used       first source of the ID instruction
//  rt_sel/rt_used       second source of the ID instruction
//  hazard               ID source matches a pending write in EX or MEM
//  sb_empty             no valid entry in EX, MEM or WB
module hazard_sb
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W    = HC_REG_W,
  parameter int SB_DEPTH = HC_SB_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_v,
  input  logic [REG_W-1:0] issue_reg,
  input  logic [REG_W-1:0] rs_sel,
  input  logic             rs_used,
  input  logic [REG_W-1:0] rt_sel,
  input  logic             rt_used,
  output logic             hazard,
  output logic             sb_empty
);

  // Valid bits cover every stage (drain needs WB too); the register number is
  // only kept for the stages that are compared, since WB reads are bypassed.
  logic [SB_DEPTH-1:0] sb_v;
  logic [REG_W-1:0]    sb_reg [SB_DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_v <= '0;
      for (int i = 0; i < SB_DEPTH-1; i++) sb_reg[i] <= '0;
    end else begin
      sb_v      <= {sb_v[SB_DEPTH-2:0], issue_v};
      sb_reg[0] <= issue_reg;
      for (int i = 1; i < SB_DEPTH-1; i++) sb_reg[i] <= sb_reg[i-1];
    end
  end

  logic match_rs, match_rt;

  always_comb begin
    match_rs = 1'b0;
    match_rt = 1'b0;
    for (int i = 0; i < SB_DEPTH-1; i++) begin
      match_rs = match_rs | (sb_v[i] & (sb_reg[i] == rs_sel));
      match_rt = match_rt | (sb_v[i] & (sb_reg[i] == rt_sel));
    end
  end

  assign hazard   = (rs_used & match_rs) | (rt_used & match_rt);
  assign sb_empty = ~|sb_v;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - decode-stage stall/bubble/flush/halt sequencing controller
//  clk, rst                   clock, synchronous active-high reset
//  id_*                       decoded fields of the instruction in ID
//  ex_branch_taken            branch in EX resolved taken this cycle
//  stall                      hold PC and IF/ID
//  bubble                     load NOP into ID/EX
//  flush                      squash IF/ID and the ID instruction
//  halt_done                  pipe empty after HALT; sticky until reset
//  stall_cycles               saturating count of stall cycles
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W    = HC_REG_W,
  parameter int SB_DEPTH = HC_SB_DEPTH,
  parameter int CNT_W    = HC_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs_sel,
  input  logic             id_rs_used,
  input  logic [REG_W-1:0] id_rt_sel,
  input  logic             id_rt_used,
  input  logic             id_regWrite,
  input  logic [REG_W-1:0] id_write_reg,
  input  logic             id_halt,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic             halt_done,
  output logic [CNT_W-1:0] stall_cycles
);

  hc_state_t state_q, state_d;
  logic      hazard, sb_empty, issue_v;

  // Stalled or squashed instructions enter EX as bubbles.
  assign issue_v = id_valid & id_regWrite & ~stall & ~flush;

  hazard_sb #(
    .REG_W   (REG_W),
    .SB_DEPTH(SB_DEPTH)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .issue_v  (issue_v),
    .issue_reg(id_write_reg),
    .rs_sel   (id_rs_sel),
    .rs_used  (id_rs_used),
    .rt_sel   (id_rt_sel),
    .rt_used  (id_rt_used),
    .hazard   (hazard),
    .sb_empty (sb_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    halt_done = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A taken branch squashes the ID instruction, so its hazard is moot.
        flush  = ex_branch_taken;
        stall  = id_valid & hazard & ~ex_branch_taken;
        bubble = stall;
        if (id_valid & id_halt & ~hazard & ~ex_branch_taken) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (ex_branch_taken) begin
          // The HALT was on the wrong path.
          flush   = 1'b1;
          state_d = ST_RUN;
        end else begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (sb_empty) state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        stall     = 1'b1;
        bubble    = 1'b1;
        halt_done = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != {CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against an issue-history model
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_rs_sel;
  logic        id_rs_used;
  logic [2:0]  id_rt_sel;
  logic        id_rt_used;
  logic        id_regWrite;
  logic [2:0]  id_write_reg;
  logic        id_halt;
  logic        ex_branch_taken;
  logic        stall, bubble, flush, halt_done;
  logic [15:0] stall_cycles;

  hazard_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_rs_sel      (id_rs_sel),
    .id_rs_used     (id_rs_used),
    .id_rt_sel      (id_rt_sel),
    .id_rt_used     (id_rt_used),
    .id_regWrite    (id_regWrite),
    .id_write_reg   (id_write_reg),
    .id_halt        (id_halt),
    .ex_branch_taken(ex_branch_taken),
    .stall          (stall),
    .bubble         (bubble),
    .flush          (flush),
    .halt_done      (halt_done),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model: hist[k] is the register written by the instruction issued k+1
  // cycles ago (-1 for none). Reads are hazards against the two newest.
  int hist [3];
  bit m_draining, m_halted;
  int m_cnt;
  bit e_stall, e_bubble, e_flush, e_done, e_haz;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) hist[k] = -1;
    m_draining = 0;
    m_halted   = 0;
    m_cnt      = 0;
  endtask

  function automatic bit reads(int r);
    return (r >= 0) && ((id_rs_used && (int'(id_rs_sel) == r)) ||
                        (id_rt_used && (int'(id_rt_sel) == r)));
  endfunction

  task automatic model_eval();
    e_haz    = reads(hist[0]) || reads(hist[1]);
    e_stall  = 0;
    e_flush  = 0;
    e_done   = 0;
    if (m_halted) begin
      e_stall = 1;
      e_done  = 1;
    end else if (m_draining) begin
      if (ex_branch_taken) e_flush = 1;
      else                 e_stall = 1;
    end else begin
      e_flush = ex_branch_taken;
      e_stall = id_valid && e_haz && !ex_branch_taken;
    end
    e_bubble = e_stall;
  endtask

  task automatic model_advance();
    int issued;
    issued = (id_valid && id_regWrite && !e_stall && !e_flush) ? int'(id_write_reg) : -1;
    if (!m_halted) begin
      if (m_draining) begin
        if (ex_branch_taken) m_draining = 0;
        else if (hist[0] < 0 && hist[1] < 0 && hist[2] < 0) begin
          m_draining = 0;
          m_halted   = 1;
        end
      end else if (id_valid && id_halt && !e_haz && !ex_branch_taken) begin
        m_draining = 1;
      end
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = issued;
    if (e_stall && m_cnt < 65535) m_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: compare outputs at the falling edge, then advance model past the rising edge.
  task automatic cycle(input bit do_chk);
    @(negedge clk);
    if (!rst) begin
      model_eval();
      if (do_chk) begin
        chk("stall", {31'b0, stall}, {31'b0, e_stall});
        chk("bubble", {31'b0, bubble}, {31'b0, e_bubble});
        chk("flush", {31'b0, flush}, {31'b0, e_flush});
        chk("halt_done", {31'b0, halt_done}, {31'b0, e_done});
        chk("stall_cycles", {16'b0, stall_cycles}, m_cnt);
      end
    end
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else     model_advance();
  endtask

  task automatic drive(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                       input bit rw, input int wr, input bit hlt, input bit br);
    id_valid        = v;
    id_rs_sel       = 3'(rs);
    id_rs_used      = rsu;
    id_rt_sel       = 3'(rt);
    id_rt_used      = rtu;
    id_regWrite     = rw;
    id_write_reg    = 3'(wr);
    id_halt         = hlt;
    ex_branch_taken = br;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1);
    rst = 1'b0;
    // Reset state.
    cycle(1);

    // 1: write r3, then read rs=3 -> two stall cycles.
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0); cycle(1);
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0); repeat (3) cycle(1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle(1);
    chk("t1_count", {16'b0, stall_cycles}, 32'd2);

    // 2: write r5, one independent, read rt=5 -> one stall.
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0); cycle(1);
    drive(1, 1, 1, 2, 1, 1, 6, 0, 0); cycle(1);
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0); repeat (2) cycle(1);
    // Two independent between -> WB bypass, no stall.
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0); cycle(1);
    drive(1, 1, 1, 2, 1, 0, 0, 0, 0); repeat (2) cycle(1);
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0); cycle(1);
    chk("t2_count", {16'b0, stall_cycles}, 32'd3);

    // 3: hazard together with taken branch -> flush only; squashed write not tracked.
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0); cycle(1);
    drive(1, 0, 1, 0, 0, 1, 4, 0, 1); cycle(1);
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0); repeat (2) cycle(1);

    // 4: write r2 then HALT -> drain, halt_done sticky.
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0); cycle(1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0); repeat (15) cycle(1);
    chk("t4_done", {31'b0, halt_done}, 32'd1);

    // Saturation: HALTED stalls every cycle, so the counter reaches all-ones.
    repeat (65600) cycle(0);
    cycle(1);
    chk("t6_saturate", {16'b0, stall_cycles}, 32'h0000_FFFF);

    // 5: HALT draining behind a write, then a taken branch -> back to RUN.
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0); cycle(1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0); repeat (2) cycle(1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1); cycle(1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); repeat (6) cycle(1);
    chk("t5_no_done", {31'b0, halt_done}, 32'd0);

    // 6: reset in the middle of a two-cycle stall.
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0); cycle(1);
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0); cycle(1);
    do_reset();
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0); cycle(1);
    chk("t6_no_stall", {31'b0, stall}, 32'd0);
    chk("t6_count", {16'b0, stall_cycles}, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      if (($urandom_range(0, 80) == 0) || (m_halted && $urandom_range(0, 3) == 0)) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
              $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 7), $urandom_range(0, 25) == 0, $urandom_range(0, 9) == 0);
        cycle(1);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
